// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file.
//   clr_state_t : bulk-clear FSM state encoding (IDLE / CLEAR / DONE)
//   merge()     : one-byte-lane merge. It is used both by the storage write path and by
//                 the read-port bypass, so the two always agree on which bytes change.
package regfile_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clr_state_t;

    // Returns new_b when the lane's byte enable is set, otherwise keeps old_b.
    function automatic logic [7:0] merge(
        input logic [7:0] old_b,
        input logic [7:0] new_b,
        input logic       be
    );
        return be ? new_b : old_b;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port of regfile_param.
//   i_raddr   : read address
//   i_mem     : current storage contents
//   i_wr_acc  : a write is being accepted this cycle (only possible in IDLE)
//   i_waddr   : write address of that write
//   i_wdata   : write data of that write
//   i_wbe     : byte enables of that write
//   o_rdata   : read data. It is 0 for an out-of-range address and for the hardwired
//               zero entry. When bypass is enabled and the read address matches an
//               accepted write, the read returns the byte-merged new value.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic [ADDR_W-1:0]   i_raddr,
    input  logic [DATA_W-1:0]   i_mem [DEPTH],
    input  logic                i_wr_acc,
    input  logic [ADDR_W-1:0]   i_waddr,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [DATA_W/8-1:0] i_wbe,
    output logic [DATA_W-1:0]   o_rdata
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic              w_in_range;
    logic              w_zero;
    logic              w_hit;
    logic [DATA_W-1:0] w_stored;
    logic [DATA_W-1:0] w_merged;

    assign w_in_range = {1'b0, i_raddr} < (ADDR_W+1)'(DEPTH);
    assign w_zero     = (ZERO_REG != 0) && (i_raddr == '0);
    // The index is only meaningful when w_in_range is true; the output mux masks it otherwise.
    assign w_stored   = i_mem[i_raddr[IDX_W-1:0]];
    assign w_hit      = (BYPASS != 0) && i_wr_acc && (i_waddr == i_raddr);

    for (genvar b = 0; b < NB; b++) begin : g_lane
        assign w_merged[8*b +: 8] = merge(w_stored[8*b +: 8], i_wdata[8*b +: 8], i_wbe[b]);
    end

    always_comb begin
        o_rdata = '0;
        if (w_in_range && !w_zero) begin
            o_rdata = w_hit ? w_merged : w_stored;
        end
    end

endmodule

// File: rtl/regfile_param.sv
// Parametrised multi-port register file with byte enables, an optional hardwired
// zero entry, optional write-to-read bypass and a sequenced bulk-clear engine.
//   i_clk       : clock, rising edge
//   i_rst_n     : asynchronous active-low reset
//   i_we        : write enable
//   i_waddr     : write address
//   i_wdata     : write data
//   i_wbe       : byte enables, bit i qualifies i_wdata[8i+7:8i]
//   i_raddr     : packed read addresses, port k uses slice k
//   o_rdata     : packed read data, port k uses slice k
//   i_clr_req   : bulk-clear request, level-sampled in IDLE only
//   o_clr_busy  : clear sequence in progress
//   o_clr_done  : one-cycle pulse when the clear sequence completes
//   o_wr_drop   : one-cycle pulse, one cycle after a write was discarded
//
// Clear FSM:
//   state    | meaning
//   ST_IDLE  | normal operation; writes accepted; i_clr_req sampled
//   ST_CLEAR | zero entry[r_clr_cnt] each cycle; writes discarded
//   ST_DONE  | single cycle with o_clr_done high; writes discarded
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_we,
    input  logic [ADDR_W-1:0]        i_waddr,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic [DATA_W/8-1:0]      i_wbe,
    input  logic [NUM_RD*ADDR_W-1:0] i_raddr,
    output logic [NUM_RD*DATA_W-1:0] o_rdata,
    input  logic                     i_clr_req,
    output logic                     o_clr_busy,
    output logic                     o_clr_done,
    output logic                     o_wr_drop
);

    localparam int              NB       = DATA_W / 8;
    localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    clr_state_t        r_state;
    clr_state_t        w_state_nxt;
    // One bit wider than the address so DEPTH == 2**ADDR_W does not wrap.
    logic [ADDR_W:0]   r_clr_cnt;
    logic              r_wr_drop;

    logic              w_in_range;
    logic              w_wr_zero;
    logic              w_be_any;
    logic              w_wr_acc;
    logic              w_wr_drop;
    logic [IDX_W-1:0]  w_widx;
    logic [IDX_W-1:0]  w_cidx;
    logic [DATA_W-1:0] w_old;
    logic [DATA_W-1:0] w_wr_merged;
    logic              w_clr_busy;
    logic              w_clr_done;

    assign w_in_range = {1'b0, i_waddr} < DEPTH_C;
    assign w_wr_zero  = (ZERO_REG != 0) && (i_waddr == '0);
    assign w_be_any   = |i_wbe;
    assign w_widx     = i_waddr[IDX_W-1:0];
    assign w_cidx     = r_clr_cnt[IDX_W-1:0];

    // A write with no byte enabled is a no-op and is never reported as dropped.
    // A write to the hardwired zero entry is silently ignored.
    assign w_wr_acc   = i_we && w_be_any && w_in_range && !w_wr_zero && (r_state == ST_IDLE);
    assign w_wr_drop  = i_we && w_be_any && (!w_in_range || (r_state != ST_IDLE));

    assign w_old = r_mem[w_widx];

    for (genvar b = 0; b < NB; b++) begin : g_wr_lane
        assign w_wr_merged[8*b +: 8] = merge(w_old[8*b +: 8], i_wdata[8*b +: 8], i_wbe[b]);
    end

    // Storage: a clear step takes priority, but the two never coincide in practice
    // because writes are only accepted in IDLE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int e = 0; e < DEPTH; e++) begin
                r_mem[e] <= '0;
            end
        end else if (r_state == ST_CLEAR) begin
            r_mem[w_cidx] <= '0;
        end else if (w_wr_acc) begin
            r_mem[w_widx] <= w_wr_merged;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clr_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + (ADDR_W+1)'(1);
        end else begin
            r_clr_cnt <= '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_drop <= 1'b0;
        end else begin
            r_wr_drop <= w_wr_drop;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (i_clr_req) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (r_clr_cnt == LAST_IDX) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_clr_busy = 1'b0;
        w_clr_done = 1'b0;
        case (r_state)
            ST_CLEAR: w_clr_busy = 1'b1;
            ST_DONE:  w_clr_done = 1'b1;
            default:  ;
        endcase
    end

    assign o_clr_busy = w_clr_busy;
    assign o_clr_done = w_clr_done;
    assign o_wr_drop  = r_wr_drop;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .DEPTH    (DEPTH),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rd_port (
            .i_raddr  (i_raddr[k*ADDR_W +: ADDR_W]),
            .i_mem    (r_mem),
            .i_wr_acc (w_wr_acc),
            .i_waddr  (i_waddr),
            .i_wdata  (i_wdata),
            .i_wbe    (i_wbe),
            .o_rdata  (o_rdata[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_regfile_param.sv
module tb_regfile_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [5:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic [5:0]  ra [2];
    logic        clr_req;

    logic [9:0]  raddr_a;
    logic [11:0] raddr_b;
    logic [63:0] rdata_a, rdata_b;
    logic        busy_a, busy_b, done_a, done_b, drop_a, drop_b;

    assign raddr_a = {ra[1][4:0], ra[0][4:0]};
    assign raddr_b = {ra[1], ra[0]};

    always #5 clk = ~clk;

    // Instance A: defaults (bypass on, no zero register).
    regfile_param dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_we(we), .i_waddr(waddr[4:0]), .i_wdata(wdata),
        .i_wbe(wbe), .i_raddr(raddr_a), .o_rdata(rdata_a), .i_clr_req(clr_req),
        .o_clr_busy(busy_a), .o_clr_done(done_a), .o_wr_drop(drop_a)
    );

    // Instance B: wider address than depth, zero register, no bypass.
    regfile_param #(.ADDR_W(6), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
        .i_wbe(wbe), .i_raddr(raddr_b), .o_rdata(rdata_b), .i_clr_req(clr_req),
        .o_clr_busy(busy_b), .o_clr_done(done_b), .o_wr_drop(drop_b)
    );

    // ---------------- reference model ----------------
    logic [31:0] m [2][32];
    int          phase;       // -1 idle, 0..31 clearing that index, 32 done cycle
    bit          drop_exp [2];
    int          n_chk = 0;
    int          n_fail = 0;

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 32; i++) m[d][i] = '0;
            drop_exp[d] = 1'b0;
        end
        phase = -1;
    endfunction

    function automatic int eaddr(int d, logic [5:0] a);
        return (d == 0) ? int'(a[4:0]) : int'(a);
    endfunction

    function automatic logic [31:0] bmerge(logic [31:0] o, logic [31:0] n, logic [3:0] be);
        logic [31:0] mask;
        for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{be[i]}};
        return (o & ~mask) | (n & mask);
    endfunction

    function automatic bit accepted(int d);
        int a = eaddr(d, waddr);
        return (phase == -1) && we && (wbe != 4'h0) && (a < 32) && !(d == 1 && a == 0);
    endfunction

    function automatic logic [31:0] exp_rd(int d, int k);
        int a = eaddr(d, ra[k]);
        if (a >= 32 || (d == 1 && a == 0)) return 32'h0;
        if (d == 0 && accepted(0) && eaddr(0, waddr) == a) return bmerge(m[d][a], wdata, wbe);
        return m[d][a];
    endfunction

    function automatic void model_edge();
        bit acc [2];
        for (int d = 0; d < 2; d++) begin
            acc[d]      = accepted(d);
            drop_exp[d] = we && (wbe != 4'h0) && (eaddr(d, waddr) >= 32 || phase != -1);
        end
        for (int d = 0; d < 2; d++) begin
            if (acc[d]) m[d][eaddr(d, waddr)] = bmerge(m[d][eaddr(d, waddr)], wdata, wbe);
            if (phase >= 0 && phase < 32) m[d][phase] = '0;
        end
        if (phase == -1) phase = clr_req ? 0 : -1;
        else if (phase == 32) phase = -1;
        else phase = phase + 1;
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic step();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rd_a%0d", k), rdata_a[k*32 +: 32], exp_rd(0, k));
            chk($sformatf("rd_b%0d", k), rdata_b[k*32 +: 32], exp_rd(1, k));
        end
        @(posedge clk);
        model_edge();
        #1;
        chk("busy_a", 32'(busy_a), 32'(phase >= 0 && phase < 32));
        chk("busy_b", 32'(busy_b), 32'(phase >= 0 && phase < 32));
        chk("done_a", 32'(done_a), 32'(phase == 32));
        chk("done_b", 32'(done_b), 32'(phase == 32));
        chk("drop_a", 32'(drop_a), 32'(drop_exp[0]));
        chk("drop_b", 32'(drop_b), 32'(drop_exp[1]));
    endtask

    task automatic idle_inputs();
        we = 1'b0; waddr = '0; wdata = '0; wbe = '0; clr_req = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit          we;
        logic [5:0]  wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [5:0]  r0, r1;
        logic [31:0] a0, a1, b0, b1;
        bit          da, db;
    } vec_t;

    function automatic vec_t mk(bit w, logic [5:0] wa, logic [31:0] wd, logic [3:0] be,
                                logic [5:0] r0, logic [5:0] r1, logic [31:0] a0, logic [31:0] a1,
                                logic [31:0] b0, logic [31:0] b1, bit da, bit db);
        vec_t v;
        v.we = w; v.wa = wa; v.wd = wd; v.be = be; v.r0 = r0; v.r1 = r1;
        v.a0 = a0; v.a1 = a1; v.b0 = b0; v.b1 = b1; v.da = da; v.db = db;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached after %0d checks, required normal completion", n_chk);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tv [10];
        int   n_busy, n_done, cyc;

        tv[0] = mk(1, 5,  32'hAABBCCDD, 4'hF, 5, 0,  32'hAABBCCDD, 32'h0,        32'h0,        32'h0,        0, 0);
        tv[1] = mk(1, 5,  32'h11223344, 4'h5, 5, 5,  32'hAA22CC44, 32'hAA22CC44, 32'hAABBCCDD, 32'hAABBCCDD, 0, 0);
        tv[2] = mk(0, 0,  32'h0,        4'h0, 5, 7,  32'hAA22CC44, 32'h0,        32'hAA22CC44, 32'h0,        0, 0);
        tv[3] = mk(1, 7,  32'h12345678, 4'hF, 7, 5,  32'h12345678, 32'hAA22CC44, 32'h0,        32'hAA22CC44, 0, 0);
        tv[4] = mk(0, 0,  32'h0,        4'h0, 7, 0,  32'h12345678, 32'h0,        32'h12345678, 32'h0,        0, 0);
        tv[5] = mk(1, 0,  32'hDEADBEEF, 4'hF, 0, 7,  32'hDEADBEEF, 32'h12345678, 32'h0,        32'h12345678, 0, 0);
        tv[6] = mk(1, 8,  32'h0BADF00D, 4'hF, 0, 40, 32'hDEADBEEF, 32'h0BADF00D, 32'h0,        32'h0,        0, 0);
        tv[7] = mk(1, 40, 32'h55555555, 4'hF, 40, 8, 32'h55555555, 32'h55555555, 32'h0,        32'h0BADF00D, 0, 1);
        tv[8] = mk(1, 9,  32'h01020304, 4'h0, 9, 8,  32'h0,        32'h55555555, 32'h0,        32'h0BADF00D, 0, 0);
        tv[9] = mk(0, 0,  32'h0,        4'h0, 9, 5,  32'h0,        32'hAA22CC44, 32'h0,        32'hAA22CC44, 0, 0);

        // ---- reset ----
        rst_n = 1'b0;
        idle_inputs();
        ra[0] = 6'd5; ra[1] = 6'd31;
        model_reset();
        #3;
        chk("rst_busy", 32'({busy_a, busy_b}), 32'h0);
        chk("rst_done", 32'({done_a, done_b}), 32'h0);
        chk("rst_drop", 32'({drop_a, drop_b}), 32'h0);
        chk("rst_rd_a", rdata_a[31:0], 32'h0);
        #7 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---- table: byte merge, bypass, zero register, range ----
        for (int i = 0; i < 10; i++) begin
            we = tv[i].we; waddr = tv[i].wa; wdata = tv[i].wd; wbe = tv[i].be;
            ra[0] = tv[i].r0; ra[1] = tv[i].r1;
            #1;
            chk($sformatf("tv%0d_a0", i), rdata_a[31:0],  tv[i].a0);
            chk($sformatf("tv%0d_a1", i), rdata_a[63:32], tv[i].a1);
            chk($sformatf("tv%0d_b0", i), rdata_b[31:0],  tv[i].b0);
            chk($sformatf("tv%0d_b1", i), rdata_b[63:32], tv[i].b1);
            @(posedge clk);
            model_edge();
            #1;
            chk($sformatf("tv%0d_drop_a", i), 32'(drop_a), 32'(tv[i].da));
            chk($sformatf("tv%0d_drop_b", i), 32'(drop_b), 32'(tv[i].db));
        end

        // ---- fill and read pairs ----
        for (int i = 0; i < 32; i++) begin
            we = 1'b1; waddr = 6'(i); wdata = 32'd2008040112 + 32'(i); wbe = 4'hF;
            ra[0] = 6'($urandom_range(0, 47)); ra[1] = 6'($urandom_range(0, 47));
            step();
        end
        idle_inputs();
        for (int i = 0; i < 32; i++) begin
            ra[0] = 6'(i); ra[1] = 6'((i + 1) % 32);
            #1;
            chk($sformatf("pair_a0_%0d", i), rdata_a[31:0],  32'd2008040112 + 32'(i));
            chk($sformatf("pair_a1_%0d", i), rdata_a[63:32], 32'd2008040112 + 32'((i + 1) % 32));
            chk($sformatf("pair_b0_%0d", i), rdata_b[31:0],  (i == 0) ? 32'h0 : 32'd2008040112 + 32'(i));
            step();
        end

        // ---- bulk clear with a dropped write in the middle ----
        ra[0] = 6'd10; ra[1] = 6'd11;
        clr_req = 1'b1;
        n_busy = 0; n_done = 0; cyc = 0;
        step();
        clr_req = 1'b0;
        if (busy_a) n_busy++;
        while (n_done == 0 && cyc < 100) begin
            if (cyc == 5) begin
                we = 1'b1; waddr = 6'd3; wdata = 32'hFFFFFFFF; wbe = 4'hF;
            end else begin
                we = 1'b0; wbe = 4'h0;
            end
            step();
            if (busy_a) n_busy++;
            if (done_a) n_done++;
            if (cyc == 10) begin
                chk("clr_e10_zero", rdata_a[31:0],  32'h0);
                chk("clr_e11_old",  rdata_a[63:32], 32'd2008040112 + 32'd11);
            end
            cyc++;
        end
        idle_inputs();
        for (int j = 0; j < 3; j++) begin
            step();
            if (done_a) n_done++;
        end
        chk("clr_busy_cycles", 32'(n_busy), 32'd32);
        chk("clr_done_pulses", 32'(n_done), 32'd1);
        for (int i = 0; i < 32; i++) begin
            ra[0] = 6'(i); ra[1] = 6'(31 - i);
            #1;
            chk($sformatf("clr_zero_%0d", i), rdata_a[31:0], 32'h0);
            step();
        end

        // ---- simultaneous write + clear request, request held high ----
        we = 1'b1; waddr = 6'd2; wdata = 32'hCAFEF00D; wbe = 4'hF; clr_req = 1'b1;
        ra[0] = 6'd2; ra[1] = 6'd20;
        n_done = 0;
        step();
        we = 1'b0; wbe = 4'h0;
        for (int j = 1; j < 68; j++) begin
            step();
            if (done_a) n_done++;
        end
        clr_req = 1'b0;
        step();
        chk("retrigger_done_pulses", 32'(n_done), 32'd2);

        // ---- reset in the middle of a clear ----
        for (int i = 0; i < 32; i++) begin
            we = 1'b1; waddr = 6'(i); wdata = $urandom | 32'h1; wbe = 4'hF;
            step();
        end
        idle_inputs();
        ra[0] = 6'd20; ra[1] = 6'd30;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int j = 0; j < 12; j++) step();
        chk("pre_rst_busy", 32'(busy_a), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy",  32'({busy_a, busy_b}), 32'h0);
        chk("midrst_done",  32'({done_a, done_b}), 32'h0);
        chk("midrst_rd_a0", rdata_a[31:0],  32'h0);
        chk("midrst_rd_a1", rdata_a[63:32], 32'h0);
        chk("midrst_rd_b0", rdata_b[31:0],  32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int j = 0; j < 4; j++) step();
        we = 1'b1; waddr = 6'd20; wdata = 32'h600DCAFE; wbe = 4'hF;
        step();
        idle_inputs();
        #1;
        chk("post_rst_write_a", rdata_a[31:0], 32'h600DCAFE);
        chk("post_rst_write_b", rdata_b[31:0], 32'h600DCAFE);
        step();

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 300; n++) begin
            we    = 1'($urandom_range(0, 1));
            waddr = 6'($urandom_range(0, 47));
            wdata = $urandom;
            wbe   = 4'($urandom_range(0, 15));
            if (waddr >= 6'd32 && wbe == 4'h0) wbe = 4'hF;
            ra[0] = 6'($urandom_range(0, 47));
            ra[1] = (n % 4 == 0) ? waddr : 6'($urandom_range(0, 47));
            step();
        end
        idle_inputs();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
